// File: rtl/ag32gbd_frame_scanner.sv
// ---------------------------------------------------------------------------
// ag32gbd_frame_scanner
//   Frame-level sequencer for the per-pixel sampler. Walks every pixel of a
//   frame in raster order, asks the sampler for each pixel's 2-bit value,
//   packs four values per byte (first pixel of the group in [7:6]) and writes
//   each completed byte to the frame buffer.
//
//   Optional feature macro: SCAN_TIMEOUT_EN
//     defined   : a watchdog aborts the frame if the sampler stalls for
//                 TIMEOUT cycles and raises the sticky scan_error flag.
//     undefined : the scanner waits on the sampler indefinitely and
//                 scan_error is tied low.
//
// Ports
//   sys_clock     in   system clock
//   sys_reset     in   synchronous active-high reset
//   frame_start   in   1-cycle pulse, begin a frame (ignored while busy)
//   frame_abort   in   level, stop after the current pixel, no more writes
//   busy          out  frame in progress
//   frame_done    out  1-cycle pulse at the end of a frame or abort
//   scan_error    out  sticky timeout flag, cleared by an accepted start
//   sample_start  out  sampler start request
//   pixel_x/y     out  pixel coordinates presented to the sampler
//   sample_done   in   sampler done (held high for several cycles)
//   sample_value  in   sampler result, valid while sample_done is high
//   fb_we         out  frame buffer write strobe
//   fb_addr       out  frame buffer byte address
//   fb_wdata      out  packed byte
// ---------------------------------------------------------------------------
module ag32gbd_frame_scanner #(
  parameter int FRAME_W    = 128,
  parameter int FRAME_H    = 112,
  parameter int START_HOLD = 3,
  parameter int TIMEOUT    = 4095,
  parameter int FB_AW      = 12
) (
  input  logic             sys_clock,
  input  logic             sys_reset,
  input  logic             frame_start,
  input  logic             frame_abort,
  output logic             busy,
  output logic             frame_done,
  output logic             scan_error,
  output logic             sample_start,
  output logic [6:0]       pixel_x,
  output logic [6:0]       pixel_y,
  input  logic             sample_done,
  input  logic [1:0]       sample_value,
  output logic             fb_we,
  output logic [FB_AW-1:0] fb_addr,
  output logic [7:0]       fb_wdata
);

  localparam int HOLD_W = $clog2(START_HOLD + 1);
  localparam int AW2    = FB_AW + 2;

  if ((FRAME_W % 4) != 0 || FRAME_W > 128 || FRAME_H > 128 || START_HOLD < 1 || TIMEOUT < 1)
  begin : g_param_check
    $error("ag32gbd_frame_scanner: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    IDLE, START, WAIT_DONE, WAIT_REL, WRITE, FINISH
  } state_t;

  state_t              state_q, state_d;
  logic [6:0]          x_q, x_d;
  logic [6:0]          y_q, y_d;
  logic [7:0]          pack_q, pack_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;

`ifdef SCAN_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic                err_q, err_d;
`endif

  always_ff @(posedge sys_clock) begin
    if (sys_reset) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      pack_q  <= '0;
      hold_q  <= '0;
`ifdef SCAN_TIMEOUT_EN
      tmo_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      pack_q  <= pack_d;
      hold_q  <= hold_d;
`ifdef SCAN_TIMEOUT_EN
      tmo_q   <= tmo_d;
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    pack_d  = pack_q;
    hold_d  = hold_q;
`ifdef SCAN_TIMEOUT_EN
    err_d   = err_q;
    tmo_d   = '0;
`endif
    case (state_q)
      IDLE: begin
        if (frame_start) begin
          x_d     = '0;
          y_d     = '0;
          hold_d  = '0;
`ifdef SCAN_TIMEOUT_EN
          err_d   = 1'b0;
`endif
          state_d = START;
        end
      end
      START: begin
        if (hold_q == HOLD_W'(START_HOLD - 1)) begin
          hold_d  = '0;
          state_d = WAIT_DONE;
        end else begin
          hold_d  = hold_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (sample_done) begin
          pack_d  = {pack_q[5:0], sample_value};
          state_d = WAIT_REL;
        end
      end
      // Leaving only once done has dropped keeps a long done pulse from
      // being captured again for the next pixel.
      WAIT_REL: begin
        if (!sample_done) begin
          if (frame_abort) begin
            state_d = FINISH;
          end else if (x_q[1:0] == 2'd3) begin
            state_d = WRITE;
          end else begin
            x_d     = x_q + 1'b1;
            state_d = START;
          end
        end
      end
      // The write strobe is decoded from this state, so it happens even
      // when abort is seen here.
      WRITE: begin
        if (x_q == 7'(FRAME_W - 1)) begin
          x_d = '0;
          if (y_q != 7'(FRAME_H - 1)) begin
            y_d = y_q + 1'b1;
          end
        end else begin
          x_d = x_q + 1'b1;
        end
        if (frame_abort || (x_q == 7'(FRAME_W - 1) && y_q == 7'(FRAME_H - 1))) begin
          state_d = FINISH;
        end else begin
          state_d = START;
        end
      end
      FINISH: begin
        x_d     = '0;
        y_d     = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

`ifdef SCAN_TIMEOUT_EN
    // Watchdog restarts on every state entry and only counts while the
    // scanner is stalled on the sampler.
    if ((state_q == WAIT_DONE || state_q == WAIT_REL) && state_d == state_q) begin
      if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
        err_d   = 1'b1;
        state_d = FINISH;
      end else begin
        tmo_d   = tmo_q + 1'b1;
      end
    end
`endif
  end

  assign busy         = (state_q != IDLE);
  assign frame_done   = (state_q == FINISH);
  assign sample_start = (state_q == START);
  assign fb_we        = (state_q == WRITE);
  assign pixel_x      = x_q;
  assign pixel_y      = y_q;
  assign fb_wdata     = pack_q;
  // Linear pixel index formed at full width, then divided by four pixels per byte.
  assign fb_addr      = FB_AW'((AW2'(y_q) * AW2'(FRAME_W) + AW2'(x_q)) >> 2);

`ifdef SCAN_TIMEOUT_EN
  assign scan_error   = err_q;
`else
  assign scan_error   = 1'b0;
`endif

endmodule
